// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit for M-extension style instructions.
//   One-bit-per-cycle shift-add multiplier and restoring divider sharing
//   a single 2*XLEN-bit accumulator, wrapped in a start/busy/done handshake.
//
//   Optional feature macro: MDU_SIGNED_EN
//     defined   -> sgn=1 selects two's-complement MUL/MULH/DIV/REM
//     undefined -> sgn is ignored, all operations unsigned
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   request, sampled only while not busy
//   op[1:0]    in   00 MUL, 01 MULH, 10 DIV, 11 REM
//   sgn        in   signed operation (only with MDU_SIGNED_EN)
//   A[XLEN]    in   multiplicand / dividend
//   B[XLEN]    in   multiplier / divisor
//   busy       out  high while iterating
//   done       out  one-cycle pulse when R becomes valid
//   R[XLEN]    out  result, held until the next done
//   dbg_state  out  current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: start is accepted on a rising edge where the unit is in IDLE or
// DONE; busy and done are registered, never high together, and R only
// changes on the edge that raises done.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            sgn,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] R,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST = 6'(XLEN - 1);

  state_t              state;
  logic [5:0]          cnt;
  logic [1:0]          op_q;
  logic                dz;        // divide by zero captured: finish next edge
  logic [XLEN-1:0]     dv;        // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc;       // mul: {partial, multiplier}; div: {rem, dividend/quotient}

  logic [XLEN-1:0]     a_mag, b_mag;
  logic                dz_in;
  logic [XLEN:0]       add_sum;
  logic [XLEN:0]       trial;
  logic                ge;
  logic [XLEN-1:0]     diff;
  logic [2*XLEN-1:0]   step;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem;
  logic [XLEN-1:0]     res;
  logic [XLEN-1:0]     dz_res;

`ifdef MDU_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_q;   // product / quotient must be negated on the final edge
  logic neg_r;   // remainder takes the dividend's sign
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
`endif

  assign dbg_state = state;
  assign dz_in     = op[1] && (B == '0);

  // Operand magnitudes at capture time.
  always_comb begin
`ifdef MDU_SIGNED_EN
    a_neg = sgn & A[XLEN-1];
    b_neg = sgn & B[XLEN-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
`else
    a_mag = A;
    b_mag = B;
`endif
  end

  // One iteration of either algorithm, plus the final result shaping.
  always_comb begin
    // Shift-add: the carry out of the add becomes the new MSB after the shift.
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dv} : '0);
    // Restoring divide: shift the next dividend bit into the partial remainder.
    trial   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge      = (trial >= {1'b0, dv});
    diff    = trial[XLEN-1:0] - dv;
    if (op_q[1])
      step = {(ge ? diff : trial[XLEN-1:0]), acc[XLEN-2:0], ge};
    else
      step = {add_sum, acc[XLEN-1:1]};

    prod = step;
    quo  = step[XLEN-1:0];
    rem  = step[2*XLEN-1:XLEN];
`ifdef MDU_SIGNED_EN
    if (neg_q) begin
      prod = -step;
      quo  = -step[XLEN-1:0];
    end
    if (neg_r)
      rem = -step[2*XLEN-1:XLEN];
`endif

    case (op_q)
      2'b00:   res = prod[XLEN-1:0];
      2'b01:   res = prod[2*XLEN-1:XLEN];
      2'b10:   res = quo;
      default: res = rem;
    endcase

    // On divide by zero the raw dividend sits in the low half of acc.
    dz_res = op_q[0] ? acc[XLEN-1:0] : '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      dz    <= 1'b0;
      dv    <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      R     <= '0;
`ifdef MDU_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        S_BUSY: begin
          if (dz) begin
            R     <= dz_res;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            acc <= step;
            cnt <= cnt + 6'd1;
            if (cnt == LAST) begin
              R     <= res;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        default: begin  // S_IDLE, S_DONE
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            cnt   <= '0;
            dz    <= dz_in;
            busy  <= !dz_in;
            state <= S_BUSY;
            if (op[1]) begin
              dv  <= b_mag;
              // Divide by zero returns the unconverted dividend for REM.
              acc <= {{XLEN{1'b0}}, (dz_in ? A : a_mag)};
            end else begin
              dv  <= a_mag;
              acc <= {{XLEN{1'b0}}, b_mag};
            end
`ifdef MDU_SIGNED_EN
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        sgn;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] R;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_r;
  logic [31:0] exp_q[$];

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn),
    .A(A), .B(B), .busy(busy), .done(done), .R(R), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each operation.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic s);
    logic [63:0] p;
    longint la, lb;
    int ia, ib;
    if (o[1] && b == 32'd0) return o[0] ? a : 32'hFFFF_FFFF;
`ifdef MDU_SIGNED_EN
    if (s) begin
      ia = a; ib = b;
      if (!o[1]) begin
        la = ia; lb = ib;
        p = 64'(la * lb);
        return o[0] ? p[63:32] : p[31:0];
      end
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return o[0] ? 32'd0 : 32'h8000_0000;
      return o[0] ? 32'(ia % ib) : 32'(ia / ib);
    end
`else
    if (s) begin end
`endif
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return a / b;
      default: return a % b;
    endcase
  endfunction

  // Drive one operation and follow it cycle by cycle to its done pulse.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input bit b2b, input bit mid_pulse);
    logic [31:0] exp;
    int lat;
    exp_q.push_back(model(o, a, b, s));
    lat = (o[1] && b == 32'd0) ? 1 : 32;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; sgn = s;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3)); sgn = 1'($urandom_range(0, 1));
    check("hs_after_start", {30'd0, busy, done}, (lat == 1) ? 32'd0 : 32'd2);
    check("r_hold_start", R, last_r);
    for (int n = 1; n <= lat; n++) begin
      if (mid_pulse && n == 5) begin
        start = 1'b1; op = 2'b00; A = $urandom; B = $urandom | 32'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (n < lat) begin
        check("hs_busy", {30'd0, busy, done}, 32'd2);
        check("r_hold_busy", R, last_r);
      end else begin
        exp = exp_q.pop_front();
        check("hs_done", {30'd0, busy, done}, 32'd1);
        check("result", R, exp);
        last_r = exp;
      end
    end
    if (!b2b) begin
      @(posedge clk); #1;
      check("hs_idle", {30'd0, busy, done}, 32'd0);
      check("r_hold_idle", R, last_r);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b0; start = 1'b0; op = 2'b00; sgn = 1'b0; A = '0; B = '0;
    last_r = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_r", R, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(2'b00, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    do_op(2'b10, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0);
    do_op(2'b11, 32'h1234, 32'd0, 1'b0, 1'b1, 1'b0);
    do_op(2'b10, 32'h1234, 32'd0, 1'b1, 1'b1, 1'b0);
    do_op(2'b11, 32'd1000, 32'd33, 1'b0, 1'b0, 1'b1);   // start during BUSY ignored
    do_op(2'b10, 32'd5, 32'd9, 1'b0, 1'b0, 1'b0);       // quotient 0
    do_op(2'b10, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
`ifdef MDU_SIGNED_EN
    do_op(2'b10, -32'sd7, 32'd2, 1'b1, 1'b1, 1'b0);
    do_op(2'b11, -32'sd7, 32'd2, 1'b1, 1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_op(2'b01, -32'sd3, 32'd5, 1'b1, 1'b0, 1'b0);
    do_op(2'b11, 32'd7, -32'sd2, 1'b1, 1'b0, 1'b0);
`endif

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    do_op(2'b00, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = 2'b00; A = 32'd123; B = 32'd456; sgn = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_r", R, 32'd0);
    last_r = '0;
    @(negedge clk); rst = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      check("no_done_after_abort", {30'd0, busy, done}, 32'd0);
    end
    check("r_after_abort", R, 32'd0);

    do_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
